window_gen: RTL and testbench

Sliding-window generator that feeds `mult_acc`. It accepts a raster-order stream of multi-channel pixels, buffers K−1 image lines per channel, and emits packed K×K windows for all channels with `window_valid`, in exactly the layout `mult_acc` expects on `multi_channel_window_in`. Stride is 1 and there is no padding, so each frame produces (IMG_HEIGHT−K+1)×(IMG_WIDTH−K+1) windows.

---
 rtl/window_gen_pkg.sv | 14 +
 rtl/window_gen_line_buffer.sv | 34 +++
 rtl/window_gen.sv | 137 +++++++++++++
 tb/tb_window_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/window_gen_pkg.sv
// Shared sliding-window constants and the window element packing helper also used by mult_acc.
package window_gen_pkg;

  localparam int unsigned DefDataWidth  = 8;
  localparam int unsigned DefKernelSize = 3;
  localparam int unsigned DefInChannel  = 3;

  // Bit offset of element (ch, i) in a packed multi-channel K x K window, i = r*K + c.
  function automatic int unsigned elem_offset(input int unsigned ch, input int unsigned i,
                                              input int unsigned k, input int unsigned dw);
    return (ch * k * k + i) * dw;
  endfunction

endpackage

// File: rtl/window_gen_line_buffer.sv
// Per-channel stack of line buffers: combinational read of all old lines, shift-on-write at addr.
module window_gen_line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_LINES  = 2,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [AddrW-1:0]                addr,
  input  logic [DATA_WIDTH-1:0]           din,
  output logic [NUM_LINES*DATA_WIDTH-1:0] dout
);

  // No reset: stale contents are masked by the window-valid gating upstream.
  logic [DATA_WIDTH-1:0] mem [NUM_LINES][DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0][addr] <= din;
      for (int j = 1; j < int'(NUM_LINES); j++) begin
        mem[j][addr] <= mem[j-1][addr];
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int j = 0; j < int'(NUM_LINES); j++) begin
      dout[j*DATA_WIDTH +: DATA_WIDTH] = mem[j][addr];
    end
  end

endmodule

// File: rtl/window_gen.sv
// Stride-1, no-padding K x K sliding-window generator over a raster multi-channel pixel stream.
// Optional WINDOW_GEN_SOF_EN adds pix_sof to force the current beat to be pixel (0,0).
module window_gen
  import window_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned KERNEL_SIZE = DefKernelSize,
  parameter int unsigned IN_CHANNEL  = DefInChannel,
  parameter int unsigned IMG_WIDTH   = 8,
  parameter int unsigned IMG_HEIGHT  = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    pix_valid,
`ifdef WINDOW_GEN_SOF_EN
  input  logic                                                    pix_sof,
`endif
  input  logic [IN_CHANNEL*DATA_WIDTH-1:0]                        pix_in,
  output logic                                                    window_valid,
  output logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                                    frame_done
);

  localparam int unsigned K    = KERNEL_SIZE;
  localparam int          KI   = int'(KERNEL_SIZE);
  localparam int          CHI  = int'(IN_CHANNEL);
  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(IMG_HEIGHT - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(K - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(K - 1);

  logic [ColW-1:0] col_q, col_d, col_cur;
  logic [RowW-1:0] row_q, row_d, row_cur;
  logic            sof;
  logic            win_ready, frame_end;
  logic            valid_q, done_q;

  logic [IN_CHANNEL-1:0][(K-1)*DATA_WIDTH-1:0]       lb_rd;
  logic [IN_CHANNEL-1:0][K-1:0][DATA_WIDTH-1:0]      col_new;
  logic [IN_CHANNEL-1:0][K-1:0][K-1:0][DATA_WIDTH-1:0] win_q;

  // Position of the current beat; a start-of-frame beat is treated as (0,0).
  always_comb begin
    sof = 1'b0;
`ifdef WINDOW_GEN_SOF_EN
    sof = pix_sof;
`endif
    col_cur = sof ? '0 : col_q;
    row_cur = sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (pix_valid) begin
      if (col_cur == ColLast) begin
        col_d = '0;
        row_d = (row_cur == RowLast) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  assign win_ready = (row_cur >= RowFirst) && (col_cur >= ColFirst);
  assign frame_end = (row_cur == RowLast) && (col_cur == ColLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= pix_valid && win_ready;
      done_q  <= pix_valid && win_ready && frame_end;
    end
  end

  for (genvar ch = 0; ch < IN_CHANNEL; ch++) begin : g_lb
    window_gen_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_LINES  (K - 1),
      .DEPTH      (IMG_WIDTH)
    ) u_line_buffer (
      .clk  (clk),
      .we   (pix_valid),
      .addr (col_cur),
      .din  (pix_in[ch*DATA_WIDTH +: DATA_WIDTH]),
      .dout (lb_rd[ch])
    );
  end

  // Incoming column, top to bottom: oldest buffered line first, live pixel last.
  always_comb begin
    col_new = '0;
    for (int ch = 0; ch < CHI; ch++) begin
      for (int r = 0; r < KI - 1; r++) begin
        col_new[ch][r] = lb_rd[ch][(KI-2-r)*int'(DATA_WIDTH) +: DATA_WIDTH];
      end
      col_new[ch][KI-1] = pix_in[ch*int'(DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (pix_valid) begin
      for (int ch = 0; ch < CHI; ch++) begin
        for (int r = 0; r < KI; r++) begin
          for (int c = 0; c < KI - 1; c++) begin
            win_q[ch][r][c] <= win_q[ch][r][c+1];
          end
          win_q[ch][r][KI-1] <= col_new[ch][r];
        end
      end
    end
  end

  always_comb begin
    window_out = '0;
    for (int ch = 0; ch < CHI; ch++) begin
      for (int r = 0; r < KI; r++) begin
        for (int c = 0; c < KI; c++) begin
          window_out[elem_offset(ch, r * KI + c, K, DATA_WIDTH) +: DATA_WIDTH] = win_q[ch][r][c];
        end
      end
    end
  end

  assign window_valid = valid_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_window_gen.sv
// Directed and randomized bench for window_gen against an image-array reference model.
module tb_window_gen;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int CH   = 3;
  localparam int W    = 5;
  localparam int H    = 4;
  localparam int PW   = CH * DW;
  localparam int WINW = CH * K * K * DW;
  localparam int NWIN = (H - K + 1) * (W - K + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pix_valid;
  logic [PW-1:0]   pix_in;
  logic            window_valid;
  logic [WINW-1:0] window_out;
  logic            frame_done;
`ifdef WINDOW_GEN_SOF_EN
  logic            pix_sof;
`endif

  always #5 clk = ~clk;

  window_gen #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .IN_CHANNEL  (CH),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_valid    (pix_valid),
`ifdef WINDOW_GEN_SOF_EN
    .pix_sof      (pix_sof),
`endif
    .pix_in       (pix_in),
    .window_valid (window_valid),
    .window_out   (window_out),
    .frame_done   (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int win_cnt, done_cnt;

  // Reference model: the frame as an image, plus the raster position of the next pixel.
  logic [PW-1:0]   img [H][W];
  int              mr, mc;
  logic [WINW-1:0] exp_win;

  function automatic logic [DW-1:0] elem(input logic [WINW-1:0] w, input int ch, input int i);
    return w[(ch*K*K + i)*DW +: DW];
  endfunction

  function automatic logic [PW-1:0] dir_pix(input int r, input int c, input logic [7:0] off);
    logic [PW-1:0] p;
    logic [3:0] r4, c4;
    r4 = r[3:0];
    c4 = c[3:0];
    p[0*DW +: DW] = off | {r4, c4};
    p[1*DW +: DW] = 8'h40 ^ {c4, r4};
    p[2*DW +: DW] = off | {2'd2, r4[2:0], c4[2:0]};
    return p;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_win(input string tag, input logic [WINW-1:0] obs,
                           input logic [WINW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, let the edge pass, then compare against the model.
  task automatic beat(input logic v, input logic [PW-1:0] p, input logic sof);
    logic exp_v, exp_d;
    pix_valid = v;
    pix_in    = p;
`ifdef WINDOW_GEN_SOF_EN
    pix_sof   = sof;
`endif
    @(posedge clk);
    #1;
    exp_v = 1'b0;
    exp_d = 1'b0;
    if (v) begin
      if (sof) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= K - 1 && mc >= K - 1) begin
        exp_v = 1'b1;
        for (int ch = 0; ch < CH; ch++)
          for (int rr = 0; rr < K; rr++)
            for (int cc = 0; cc < K; cc++)
              exp_win[(ch*K*K + rr*K + cc)*DW +: DW] = img[mr-K+1+rr][mc-K+1+cc][ch*DW +: DW];
      end
      exp_d = exp_v && mr == H - 1 && mc == W - 1;
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end
    check_bit("window_valid", window_valid, exp_v);
    check_bit("frame_done", frame_done, exp_d);
    if (exp_v) check_win("window_out", window_out, exp_win);
    if (window_valid) win_cnt++;
    if (frame_done) done_cnt++;
    pix_valid = 1'b0;
`ifdef WINDOW_GEN_SOF_EN
    pix_sof   = 1'b0;
`endif
  endtask

  // kind 0: directed pattern with spot checks; kind 1: random pixels.
  task automatic send_frame(input int kind, input logic [7:0] off, input int bubble_pct,
                            input logic sof);
    logic [PW-1:0] p;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int b = 0; b < 4 && int'($urandom_range(99)) < bubble_pct; b++)
          beat(1'b0, PW'($urandom), 1'b0);
        p = (kind == 0) ? dir_pix(r, c, off) : PW'($urandom);
        beat(1'b1, p, sof && r == 0 && c == 0);
        if (kind == 0 && r == K - 1 && c == K - 1) begin
          check_byte("first_i0", elem(window_out, 0, 0), off | 8'h00);
          check_byte("first_i4", elem(window_out, 0, 4), off | 8'h11);
          check_byte("first_i8", elem(window_out, 0, 8), off | 8'h22);
          check_byte("first_ch2_i8", elem(window_out, 2, 8), 8'h92);
        end
        if (kind == 0 && r == H - 1 && c == W - 1) begin
          check_byte("last_i0", elem(window_out, 0, 0), off | 8'h12);
          check_byte("last_i8", elem(window_out, 0, 8), off | 8'h34);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
`ifdef WINDOW_GEN_SOF_EN
    pix_sof   = 1'b0;
`endif
    mr = 0;
    mc = 0;
    exp_win = '0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_valid", window_valid, 1'b0);
    check_bit("reset_done", frame_done, 1'b0);
    check_win("reset_window", window_out, '0);
    rst_n = 1'b1;

    // Basic frame, continuous valid.
    win_cnt = 0; done_cnt = 0;
    send_frame(0, 8'h00, 0, 1'b0);
    check_int("basic_windows", win_cnt, NWIN);
    check_int("basic_frame_done", done_cnt, 1);

    // Same frame with random bubbles.
    win_cnt = 0; done_cnt = 0;
    send_frame(0, 8'h00, 50, 1'b0);
    check_int("bubble_windows", win_cnt, NWIN);
    check_int("bubble_frame_done", done_cnt, 1);

    // Back-to-back frames, second offset by 0x80.
    win_cnt = 0; done_cnt = 0;
    send_frame(0, 8'h00, 0, 1'b0);
    send_frame(0, 8'h80, 0, 1'b0);
    check_int("b2b_windows", win_cnt, 2 * NWIN);
    check_int("b2b_frame_done", done_cnt, 2);

    // Reset after pixel (2,3), then a full frame.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W && !(r == 2 && c > 3); c++)
        beat(1'b1, dir_pix(r, c, 8'h00), 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_bit("midrst_valid", window_valid, 1'b0);
      check_bit("midrst_done", frame_done, 1'b0);
      check_win("midrst_window", window_out, '0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    mr = 0;
    mc = 0;
    win_cnt = 0; done_cnt = 0;
    send_frame(0, 8'h00, 0, 1'b0);
    check_int("postrst_windows", win_cnt, NWIN);
    check_int("postrst_frame_done", done_cnt, 1);

    // Random frames with bubbles.
    win_cnt = 0; done_cnt = 0;
    for (int f = 0; f < 3; f++) send_frame(1, 8'h00, 30, 1'b0);
    check_int("rand_windows", win_cnt, 3 * NWIN);
    check_int("rand_frame_done", done_cnt, 3);

`ifdef WINDOW_GEN_SOF_EN
    // Truncated frame, then resync with start-of-frame.
    for (int i = 0; i < 7; i++) beat(1'b1, PW'($urandom), 1'b0);
    win_cnt = 0; done_cnt = 0;
    send_frame(0, 8'h00, 0, 1'b1);
    check_int("sof_windows", win_cnt, NWIN);
    check_int("sof_frame_done", done_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
